// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one signed fixed-point saturating multiplier among NREQ requesters.
// Optional saturation-event counter enabled by defining MULT_ARBITER_SATCNT_EN.
module mult_arbiter #(
    parameter int DECIM = 16,
    parameter int MAGN  = 8,
    parameter int N     = DECIM + MAGN + 1,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] op_a,
    input  logic [NREQ*N-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              res_valid,
    output logic [IDW-1:0]    res_id,
    output logic [N-1:0]      res,
    output logic [15:0]       sat_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Symmetric clamp limits at product width; the most-negative code is never produced.
    localparam logic signed [2*N-1:0] SAT_POS = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] SAT_NEG = -SAT_POS;

    state_t                  state_q;
    logic [IDW-1:0]          rr_q;
    logic [IDW-1:0]          id_q;
    logic signed [N-1:0]     a_q;
    logic signed [N-1:0]     b_q;
    logic signed [2*N-1:0]   prod_q;
    logic [NREQ-1:0]         gnt_q;
    logic                    res_valid_q;
    logic [IDW-1:0]          res_id_q;
    logic [N-1:0]            res_q;

    logic                    win_found;
    logic [IDW-1:0]          win_idx;
    logic [NREQ-1:0]         win_onehot;
    logic [IDW-1:0]          rr_d;
    logic signed [2*N-1:0]   sh;
    logic                    ovf;
    logic                    udf;
    logic [N-1:0]            res_d;

    // First set request at or above the rr pointer, wrapping back to requester 0.
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = IDW'(cand);
            end
        end
    end

    assign win_onehot = NREQ'(1) << win_idx;
    assign rr_d       = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    // Arithmetic shift floors toward -infinity before clamping.
    assign sh    = prod_q >>> DECIM;
    assign ovf   = sh > SAT_POS;
    assign udf   = sh < SAT_NEG;
    assign res_d = ovf ? SAT_POS[N-1:0] : (udf ? SAT_NEG[N-1:0] : sh[N-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            prod_q      <= '0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    res_valid_q <= 1'b0;
                    if (win_found) begin
                        gnt_q   <= win_onehot;
                        a_q     <= op_a[win_idx*N +: N];
                        b_q     <= op_b[win_idx*N +: N];
                        id_q    <= win_idx;
                        rr_q    <= rr_d;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    gnt_q   <= '0;
                    prod_q  <= (2*N)'(a_q) * (2*N)'(b_q);
                    state_q <= OUT;
                end
                OUT: begin
                    res_q       <= res_d;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res       = res_q;

`ifdef MULT_ARBITER_SATCNT_EN
    logic [15:0] sat_cnt_q;

    // Sticky at all-ones so a long run of clamps never wraps back to a small count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (state_q == OUT && (ovf || udf) && sat_cnt_q != 16'hFFFF) begin
            sat_cnt_q <= sat_cnt_q + 16'd1;
        end
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter: grant timing, arithmetic, saturation, round-robin order and reset abort.
// Results are matched against an expected queue filled at stimulus time.
module tb_mult_arbiter;

    localparam int DECIM = 16;
    localparam int MAGN  = 8;
    localparam int N     = DECIM + MAGN + 1;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int W     = IDW + N;
`ifdef MULT_ARBITER_SATCNT_EN
    localparam bit SATCNT = 1'b1;
`else
    localparam bit SATCNT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] op_a;
    logic [NREQ*N-1:0] op_b;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              res_valid;
    logic [IDW-1:0]    res_id;
    logic [N-1:0]      res;
    logic [15:0]       sat_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sat  = 0;
    logic [W-1:0] exp_q[$];

    mult_arbiter #(.DECIM(DECIM), .MAGN(MAGN), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .busy(busy), .res_valid(res_valid), .res_id(res_id),
        .res(res), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arithmetic in 64-bit integers, independent of bit-slicing.
    function automatic longint sh_of(input longint a, input longint b);
        longint p;
        p = a * b;
        return p >>> DECIM;
    endfunction

    function automatic bit sat_of(input longint a, input longint b);
        longint mx;
        mx = (longint'(1) << (N - 1)) - 1;
        return (sh_of(a, b) > mx) || (sh_of(a, b) < -mx);
    endfunction

    function automatic logic [N-1:0] model(input longint a, input longint b);
        longint mx;
        longint s;
        mx = (longint'(1) << (N - 1)) - 1;
        s  = sh_of(a, b);
        if (s > mx) s = mx;
        else if (s < -mx) s = -mx;
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] to_n(input longint v);
        return v[N-1:0];
    endfunction

    task automatic set_op(input int id, input longint a, input longint b);
        op_a[id*N +: N] = a[N-1:0];
        op_b[id*N +: N] = b[N-1:0];
    endtask

    // One isolated operation from IDLE, checking the grant/busy/valid timeline.
    task automatic single_op(input int id, input longint a, input longint b, input logic [N-1:0] exp_res);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[id] = 1'b1;
        set_op(id, a, b);
        req = oh;
        exp_q.push_back({IDW'(id), exp_res});
        if (sat_of(a, b) && exp_sat < 65535) exp_sat++;
        @(negedge clk);
        check("gnt_onehot", 64'(gnt), 64'(oh));
        check("busy_calc", 64'(busy), 64'd1);
        req = '0;
        @(negedge clk);
        check("gnt_drop", 64'(gnt), 64'd0);
        check("valid_early", 64'(res_valid), 64'd0);
        @(negedge clk);
        check("valid_pulse", 64'(res_valid), 64'd1);
        check("busy_idle", 64'(busy), 64'd0);
        @(negedge clk);
        check("valid_end", 64'(res_valid), 64'd0);
    endtask

    always @(negedge clk) begin
        if (res_valid === 1'b1) begin
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_result: observed id=%0d res=%0h, expected no result", res_id, res);
            end
            if (exp_q.size() != 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("result", 64'({res_id, res}), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req   = '1;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_res_id", 64'(res_id), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sat", 64'(sat_count), 64'd0);

        // First edge out of reset grants requester 0 (operands zero).
        exp_q.push_back({IDW'(0), N'(0)});
        rst_n = 1'b1;
        @(negedge clk);
        check("gnt_after_rst", 64'(gnt), 64'h1);
        req = '0;
        repeat (3) @(negedge clk);

        single_op(2, 64'sh18000, 64'sh20000, to_n(64'sh30000));
        check("res_hold", 64'(res), 64'h30000);
        single_op(1, -64'sh10000, 64'sh08000, to_n(-64'sh8000));
        single_op(0, 0, 64'sh7FFFFF, to_n(0));
        single_op(3, 64'shC80000, 64'sh20000, to_n(64'd16777215));
        single_op(0, -64'shC80000, 64'sh20000, to_n(-64'd16777215));
        check("sat_count_two", 64'(sat_count), SATCNT ? 64'd2 : 64'd0);

        // Exact limits are not clamped; a tiny negative product floors to -1 LSB.
        single_op(1, 64'shFFFFFF, 64'sh10000, to_n(64'shFFFFFF));
        single_op(2, -64'shFFFFFF, 64'sh10000, to_n(-64'shFFFFFF));
        single_op(3, -64'sd1, 64'sh08000, to_n(-64'sd1));
        check("sat_count_edges", 64'(sat_count), SATCNT ? 64'd2 : 64'd0);

        for (int k = 0; k < 6; k++) begin
            int id;
            longint a;
            longint b;
            id = $urandom_range(0, NREQ - 1);
            a  = longint'($urandom_range(0, 32'h1FFFFFE)) - 64'sd16777215;
            b  = longint'($urandom_range(0, 32'h3FFFF)) - 64'sh20000;
            single_op(id, a, b, model(a, b));
        end
        check("sat_count_rand", 64'(sat_count), SATCNT ? 64'(exp_sat) : 64'd0);

        // Reset while in CALC abandons the operation.
        set_op(3, 64'sh10000, 64'sh10000);
        req = 4'b1000;
        @(negedge clk);
        check("gnt_abort", 64'(gnt), 64'h8);
        req = '0;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_gnt", 64'(gnt), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_valid", 64'(res_valid), 64'd0);
        end
        check("abort_sat", 64'(sat_count), 64'd0);

        // All requesters held: strict rotation 0,1,2,3,0 one grant per 3 cycles.
        for (int i = 0; i < NREQ; i++) set_op(i, longint'(i + 1) * 64'sh10000, 64'sh18000);
        req = '1;
        for (int g = 0; g < 5; g++) begin
            int id;
            id = g % NREQ;
            exp_q.push_back({IDW'(id), to_n(longint'(id + 1) * 64'sh18000)});
            @(negedge clk);
            check("rr_gnt", 64'(gnt), 64'(1) << id);
            if (g == 4) req = '0;
            @(negedge clk);
            check("rr_gnt_low", 64'(gnt), 64'd0);
            @(negedge clk);
            check("rr_valid", 64'(res_valid), 64'd1);
        end
        @(negedge clk);
        check("idle_gnt", 64'(gnt), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
